multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles a memory access waits for mem_ready before trapping.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level enable; 1 = keep executing, 0 = stop at next instruction boundary.
REQ-005 opcode  input  7  instruction opcode from IR; sampled in DECODE only.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 alu_zero  input  1  ALU zero flag, valid in EXEC.
REQ-008 pc_write, ir_write, mem_req, mem_we, iord, reg_write, mem_to_reg, alu_src  output  1 each  datapath controls (iord: 0 = PC address, 1 = ALU address).
REQ-009 alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-010 state  output  3  current FSM state encoding.
REQ-011 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-012 retired  output  16  retired-instruction count.
REQ-013 trap  output  1  sticky fault flag; trap_cause output 2: 00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-014 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 unreachable, treated as TRAP.
REQ-015 IDLE: all controls 0; run=1 -> FETCH next cycle.
REQ-016 FETCH: mem_req=1, iord=0, mem_we=0; on cycle with mem_ready=1, ir_write=1 and pc_write=1 in that same cycle (Mealy), -> DECODE.
REQ-017 DECODE: classify opcode (0110011 R, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH) into registered class; legal -> EXEC; else -> TRAP, cause 01.
REQ-018 EXEC: R: alu_src=0, alu_op=10 -> WB; LOAD/STORE: alu_src=1, alu_op=00 -> MEM; BRANCH: alu_src=0, alu_op=01, pc_write=alu_zero, retire -> boundary.
REQ-019 MEM: mem_req=1, iord=1, mem_we=1 for STORE only; hold until mem_ready; LOAD -> WB; STORE retires -> boundary.
REQ-020 WB: reg_write=1, mem_to_reg=1 for LOAD else 0; retire -> boundary.
REQ-021 Boundary: next state FETCH if run=1, IDLE if run=0; run changes mid-instruction have no effect until boundary.
REQ-022 Retire: instr_done=1 for exactly the retiring cycle; retired increments by 1, wraps 0xFFFF -> 0x0000.
REQ-023 Wait counter clears on entry to FETCH/MEM, increments each cycle mem_ready=0; reaching MEM_TIMEOUT without mem_ready -> TRAP, cause 10; mem_ready on the final allowed cycle completes normally.
REQ-024 TRAP: all datapath controls 0, trap=1, trap_cause held; exits only via rst_n.
REQ-025 Outputs other than REQ-016/018 Mealy terms decode from the state and class registers only; no combinational path from run or opcode to outputs.

Reset
REQ-026 rst_n=0 immediately forces state=IDLE, class cleared, wait counter=0, retired=0, trap=0, trap_cause=00, all controls and instr_done 0, including mid-access; first FETCH starts no earlier than the first edge after release with run=1.

Structure
REQ-027 State enum, instruction-class enum, opcode constants and alu_op encodings live in shared package cpu_pkg, also used by the single-cycle control unit.
REQ-028 Opcode classification is a combinational sub-module instr_class_decode (opcode in, class and legal out); the FSM, counters and trap logic stay in multicycle_ctrl.

Verification
REQ-029 Reset then run=1, R-type 0110011, mem_ready on 2nd FETCH cycle -> states 1,2,3,5; reg_write=1 in WB; instr_done pulse; retired=1.
REQ-030 LOAD 0000011, MEM mem_ready after 3 waits -> mem_req/iord=1 for 4 cycles, WB mem_to_reg=1; STORE 0100011 -> mem_we=1 in MEM, no WB, retires from MEM.
REQ-031 BRANCH with alu_zero=1 then 0 -> pc_write=1 in EXEC for the first only; both retire; retired=2.
REQ-032 opcode 0010011 -> TRAP, trap_cause=01, controls 0 for 20 cycles; rst_n pulse returns to IDLE with trap=0.
REQ-033 mem_ready held 0 in FETCH -> TRAP with cause 10 after exactly 16 cycles; separately, mem_ready on 16th cycle -> DECODE.
REQ-034 Preload retired=0xFFFF via 65535 R-types (or force) -> next retire gives 0x0000; run=0 mid-EXEC -> instruction completes, then IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle and multicycle control units:
// FSM states, instruction classes, opcodes, ALU operation and trap encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6,
        ST_BAD    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } iclass_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_mem_class(input iclass_t c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps a 7-bit opcode onto an instruction
// class and flags anything outside the supported set as illegal.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = CLS_NONE;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                iclass = CLS_R;
                legal  = 1'b1;
            end
            OP_LOAD: begin
                iclass = CLS_LOAD;
                legal  = 1'b1;
            end
            OP_STORE: begin
                iclass = CLS_STORE;
                legal  = 1'b1;
            end
            OP_BRANCH: begin
                iclass = CLS_BRANCH;
                legal  = 1'b1;
            end
            default: begin
                iclass = CLS_NONE;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [15:0] retired,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    iclass_t           class_q;
    iclass_t           dec_class;
    logic              dec_legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       retired_q;
    logic              trap_q;
    logic [1:0]        cause_q;
    logic              retire;
    logic              cause_load;
    logic [1:0]        cause_d;
    logic              timed_out;
    state_t            boundary;

    instr_class_decode u_decode (
        .opcode (opcode),
        .iclass (dec_class),
        .legal  (dec_legal)
    );

    assign timed_out = !mem_ready && (wait_cnt == LAST_WAIT);
    assign boundary  = run ? ST_FETCH : ST_IDLE;

    // Next-state and control decode; only the fetch strobes, branch pc_write
    // and memory-completion retire look at live inputs.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        cause_load = 1'b0;
        cause_d    = CAUSE_NONE;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timed_out) begin
                    state_d    = ST_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d    = ST_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (class_q == CLS_R) begin
                    alu_op  = ALU_FUNCT;
                    state_d = ST_WB;
                end else if (is_mem_class(class_q)) begin
                    alu_src = 1'b1;
                    state_d = ST_MEM;
                end else if (class_q == CLS_BRANCH) begin
                    alu_op   = ALU_SUB;
                    pc_write = alu_zero;
                    retire   = 1'b1;
                    state_d  = boundary;
                end else begin
                    state_d    = ST_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_ILLEGAL;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (class_q == CLS_STORE);
                if (mem_ready) begin
                    if (class_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timed_out) begin
                    state_d    = ST_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CLS_LOAD);
                retire     = 1'b1;
                state_d    = boundary;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            class_q <= CLS_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) class_q <= dec_class;
        end
    end

    // The wait counter restarts whenever a memory-access state is freshly entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM)) begin
            wait_cnt <= '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'd0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            if (retire) retired_q <= retired_q + 16'd1;
            if (state_d == ST_TRAP) trap_q <= 1'b1;
            if (cause_load) cause_q <= cause_d;
        end
    end

    assign state      = state_q;
    assign instr_done = retire;
    assign retired    = retired_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: each scenario task drives
// one instruction flow and compares outputs against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        alu_zero;
    logic        pc_write, ir_write, mem_req, mem_we, iord;
    logic        reg_write, mem_to_reg, alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        instr_done;
    logic [15:0] retired;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [9:0]  ctrl;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign ctrl = {pc_write, ir_write, mem_req, mem_we, iord, reg_write, mem_to_reg, alu_src, alu_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 7'd0; alu_zero = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; alu_zero = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if ({ctrl, instr_done} !== 11'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 000", {ctrl, instr_done}); end
        checks++; if ({trap, trap_cause, retired} !== 19'd0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {trap, trap_cause, retired}); end
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0; mem_ready = 1'b0;
        cyc();
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
        cyc();
        run = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_before_edge: got %0d expected 0", state); end
        cyc();
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL idle_to_fetch: got %0d expected 1", state); end
    endtask

    task automatic test_rtype();
        apply_reset();
        run = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if ({state, mem_req, iord, mem_we, ir_write, pc_write} !== {3'd1, 5'b10000}) begin
            errors++; $display("FAIL r_fetch_wait: got %b expected 00110000", {state, mem_req, iord, mem_we, ir_write, pc_write}); end
        cyc();
        mem_ready = 1'b1; opcode = 7'b0110011;
        @(negedge clk);
        checks++; if ({state, ir_write, pc_write} !== {3'd1, 2'b11}) begin
            errors++; $display("FAIL r_fetch_ready: got %b expected 00111", {state, ir_write, pc_write}); end
        cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({state, ctrl} !== {3'd2, 10'd0}) begin errors++; $display("FAIL r_decode: got %h expected 800", {state, ctrl}); end
        cyc();
        opcode = 7'd0;
        @(negedge clk);
        checks++; if ({state, alu_src, alu_op} !== {3'd3, 1'b0, 2'b10}) begin
            errors++; $display("FAIL r_exec: got %b expected 011010", {state, alu_src, alu_op}); end
        cyc();
        run = 1'b0;
        @(negedge clk);
        checks++; if ({state, reg_write, mem_to_reg, instr_done} !== {3'd5, 3'b101}) begin
            errors++; $display("FAIL r_wb: got %b expected 101101", {state, reg_write, mem_to_reg, instr_done}); end
        cyc();
        @(negedge clk);
        checks++; if ({state, instr_done, retired} !== {3'd0, 1'b0, 16'd1}) begin
            errors++; $display("FAIL r_retire: got state=%0d done=%0d retired=%0d expected 0 0 1", state, instr_done, retired); end
    endtask

    task automatic test_load_store();
        apply_reset();
        run = 1'b1;
        cyc();
        mem_ready = 1'b1; opcode = 7'b0000011;
        cyc();
        mem_ready = 1'b0;
        cyc();
        @(negedge clk);
        checks++; if ({state, alu_src, alu_op} !== {3'd3, 1'b1, 2'b00}) begin
            errors++; $display("FAIL ld_exec: got %b expected 011100", {state, alu_src, alu_op}); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            checks++; if ({state, mem_req, iord, mem_we, instr_done} !== {3'd4, 4'b1100}) begin
                errors++; $display("FAIL ld_mem%0d: got %b expected 1001100", i, {state, mem_req, iord, mem_we, instr_done}); end
            cyc();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({state, reg_write, mem_to_reg, instr_done} !== {3'd5, 3'b111}) begin
            errors++; $display("FAIL ld_wb: got %b expected 101111", {state, reg_write, mem_to_reg, instr_done}); end
        cyc();
        mem_ready = 1'b1; opcode = 7'b0100011;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL st_fetch: got %0d expected 1", state); end
        cyc();
        mem_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        checks++; if ({state, mem_we, iord, instr_done} !== {3'd4, 3'b110}) begin
            errors++; $display("FAIL st_mem_wait: got %b expected 100110", {state, mem_we, iord, instr_done}); end
        cyc();
        mem_ready = 1'b1; run = 1'b0;
        @(negedge clk);
        checks++; if ({state, mem_we, instr_done} !== {3'd4, 2'b11}) begin
            errors++; $display("FAIL st_mem_ready: got %b expected 10011", {state, mem_we, instr_done}); end
        cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({state, retired} !== {3'd0, 16'd2}) begin
            errors++; $display("FAIL st_retire: got state=%0d retired=%0d expected 0 2", state, retired); end
    endtask

    task automatic test_branch();
        apply_reset();
        run = 1'b1;
        cyc();
        mem_ready = 1'b1; opcode = 7'b1100011;
        cyc();
        mem_ready = 1'b0;
        cyc();
        alu_zero = 1'b1;
        @(negedge clk);
        checks++; if ({state, pc_write, alu_op, alu_src, instr_done} !== {3'd3, 1'b1, 2'b01, 1'b0, 1'b1}) begin
            errors++; $display("FAIL br_taken: got %b expected 01110101", {state, pc_write, alu_op, alu_src, instr_done}); end
        cyc();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL br_refetch: got %0d expected 1", state); end
        cyc();
        mem_ready = 1'b0;
        cyc();
        alu_zero = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++; if ({state, pc_write, instr_done} !== {3'd3, 2'b01}) begin
            errors++; $display("FAIL br_not_taken: got %b expected 01101", {state, pc_write, instr_done}); end
        cyc();
        @(negedge clk);
        checks++; if ({state, retired} !== {3'd0, 16'd2}) begin
            errors++; $display("FAIL br_retire: got state=%0d retired=%0d expected 0 2", state, retired); end
    endtask

    task automatic test_illegal_trap();
        apply_reset();
        run = 1'b1;
        cyc();
        mem_ready = 1'b1; opcode = 7'b0010011;
        cyc();
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; alu_zero = i[1]; opcode = 7'b0110011;
            @(negedge clk);
            checks++; if ({state, trap, trap_cause, ctrl, instr_done} !== {3'd6, 1'b1, 2'b01, 11'd0}) begin
                errors++; $display("FAIL trap_hold%0d: got state=%0d trap=%0d cause=%b ctrl=%h done=%0d expected 6 1 01 000 0",
                                   i, state, trap, trap_cause, ctrl, instr_done); end
            cyc();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({state, trap, trap_cause} !== {3'd0, 1'b0, 2'b00}) begin
            errors++; $display("FAIL trap_reset: got state=%0d trap=%0d cause=%b expected 0 0 00", state, trap, trap_cause); end
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        run = 1'b1;
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if ({state, mem_req, trap} !== {3'd1, 2'b10}) begin
                errors++; $display("FAIL to_fetch%0d: got state=%0d req=%0d trap=%0d expected 1 1 0", i, state, mem_req, trap); end
            cyc();
        end
        @(negedge clk);
        checks++; if ({state, trap, trap_cause, ctrl} !== {3'd6, 1'b1, 2'b10, 10'd0}) begin
            errors++; $display("FAIL to_trap: got state=%0d trap=%0d cause=%b ctrl=%h expected 6 1 10 000", state, trap, trap_cause, ctrl); end
        apply_reset();
        run = 1'b1;
        cyc();
        opcode = 7'b0110011;
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 15);
            cyc();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({state, trap} !== {3'd2, 1'b0}) begin
            errors++; $display("FAIL to_last_cycle: got state=%0d trap=%0d expected 2 0", state, trap); end
    endtask

    task automatic test_wrap_and_stop();
        apply_reset();
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        #1;
        checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", retired); end
        cyc();
        run = 1'b1;
        cyc();
        mem_ready = 1'b1; opcode = 7'b0110011;
        cyc();
        mem_ready = 1'b0;
        cyc();
        run = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL stop_exec: got %0d expected 3", state); end
        cyc();
        @(negedge clk);
        checks++; if ({state, instr_done, retired} !== {3'd5, 1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL stop_wb: got state=%0d done=%0d retired=%h expected 5 1 ffff", state, instr_done, retired); end
        cyc();
        @(negedge clk);
        checks++; if ({state, retired} !== {3'd0, 16'h0000}) begin
            errors++; $display("FAIL wrap_retire: got state=%0d retired=%h expected 0 0000", state, retired); end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 7'd0; alu_zero = 1'b0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_illegal_trap();
        test_timeout();
        test_wrap_and_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
